// File: rtl/dds_meas_pkg.sv
// Shared constants and FSM encoding for the DDS frequency meter.
package dds_meas_pkg;

   localparam int unsigned DAT_W_DEF  = 16;
   localparam int unsigned CNT_W_DEF  = 32;
   localparam int unsigned NCYC_W_DEF = 8;
   localparam int unsigned FW_W       = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2,
      ST_DONE = 2'd3
   } meas_state_e;

endpackage

// File: rtl/dds_freq_meter_if.sv
// Control, sample and result signals of the frequency meter.
interface dds_freq_meter_if
   import dds_meas_pkg::*;
#(
   parameter int unsigned DAT_W  = DAT_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned NCYC_W = NCYC_W_DEF
) ();

   logic              start;
   logic [NCYC_W-1:0] ncyc;
   logic [DAT_W-1:0]  thr_hi;
   logic [DAT_W-1:0]  thr_lo;
   logic [CNT_W-1:0]  timeout_lim;
   logic              din_vld;
   logic [DAT_W-1:0]  din;
   logic              busy;
   logic              meas_vld;
   logic [CNT_W-1:0]  meas_cnt;
   logic              timeout;

   modport master (
      output start, ncyc, thr_hi, thr_lo, timeout_lim, din_vld, din,
      input  busy, meas_vld, meas_cnt, timeout
   );

   modport slave (
      input  start, ncyc, thr_hi, thr_lo, timeout_lim, din_vld, din,
      output busy, meas_vld, meas_cnt, timeout
   );

endinterface

// File: rtl/zc_hyst_detect.sv
// Schmitt-trigger level tracker with a rising-crossing strobe.
module zc_hyst_detect
   import dds_meas_pkg::*;
#(
   parameter int unsigned DAT_W = DAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_vld,
   input  logic [DAT_W-1:0] din,
   input  logic [DAT_W-1:0] thr_hi,
   input  logic [DAT_W-1:0] thr_lo,
   output logic             hyst,
   output logic             rise
);

   logic hyst_q;
   logic hyst_d;

   // The upper threshold wins when the thresholds are inverted
   always_comb begin
      hyst_d = hyst_q;
      if (din_vld) begin
         if (din >= thr_hi) begin
            hyst_d = 1'b1;
         end else if (din <= thr_lo) begin
            hyst_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hyst_q <= 1'b0;
      end else begin
         hyst_q <= hyst_d;
      end
   end

   assign hyst = hyst_q;
   assign rise = din_vld & ~hyst_q & hyst_d;

endmodule

// File: rtl/dds_freq_meter.sv
// Measures the span in valid samples of ncyc waveform periods, with timeout.
module dds_freq_meter
   import dds_meas_pkg::*;
#(
   parameter int unsigned DAT_W  = DAT_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned NCYC_W = NCYC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   dds_freq_meter_if.slave  bus
);

   meas_state_e       state_q, state_d;
   logic [NCYC_W-1:0] ncyc_q, ncyc_d;
   logic [NCYC_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0]  lim_q, lim_d;
   logic [CNT_W-1:0]  tot_q, tot_d;
   logic [CNT_W-1:0]  per_q, per_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              to_q, to_d;
   logic              busy_q, busy_d;
   logic              vld_q, vld_d;

   logic              zc_hyst_unused;
   logic              rise;
   logic [CNT_W-1:0]  tot_inc;
   logic [CNT_W-1:0]  per_inc;
   logic [NCYC_W-1:0] cyc_inc;
   logic              lim_hit;

   zc_hyst_detect #(.DAT_W(DAT_W)) u_zc (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_vld (bus.din_vld),
      .din     (bus.din),
      .thr_hi  (bus.thr_hi),
      .thr_lo  (bus.thr_lo),
      .hyst    (zc_hyst_unused),
      .rise    (rise)
   );

   assign tot_inc = tot_q + CNT_W'(1);
   assign per_inc = per_q + CNT_W'(1);
   assign cyc_inc = cyc_q + NCYC_W'(1);
   assign lim_hit = (lim_q != '0) && (tot_inc == lim_q);

   // Next-state, counters and result
   always_comb begin
      state_d = state_q;
      ncyc_d  = ncyc_q;
      cyc_d   = cyc_q;
      lim_d   = lim_q;
      tot_d   = tot_q;
      per_d   = per_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               ncyc_d  = (bus.ncyc == '0) ? NCYC_W'(1) : bus.ncyc;
               lim_d   = bus.timeout_lim;
               tot_d   = '0;
               per_d   = '0;
               cyc_d   = '0;
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            // An arming crossing never completes, so the timeout wins here
            if (bus.din_vld) begin
               tot_d = tot_inc;
               if (lim_hit) begin
                  cnt_d   = '0;
                  to_d    = 1'b1;
                  state_d = ST_DONE;
               end else if (rise) begin
                  per_d   = '0;
                  cyc_d   = '0;
                  state_d = ST_MEAS;
               end
            end
         end
         ST_MEAS: begin
            if (bus.din_vld) begin
               tot_d = tot_inc;
               per_d = per_inc;
               if (rise) begin
                  cyc_d = cyc_inc;
               end
               if (rise && (cyc_inc == ncyc_q)) begin
                  cnt_d   = per_inc;
                  to_d    = 1'b0;
                  state_d = ST_DONE;
               end else if (lim_hit || (&per_q)) begin
                  cnt_d   = '0;
                  to_d    = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      vld_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ncyc_q  <= '0;
         cyc_q   <= '0;
         lim_q   <= '0;
         tot_q   <= '0;
         per_q   <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         busy_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ncyc_q  <= ncyc_d;
         cyc_q   <= cyc_d;
         lim_q   <= lim_d;
         tot_q   <= tot_d;
         per_q   <= per_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         busy_q  <= busy_d;
         vld_q   <= vld_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.meas_vld = vld_q;
   assign bus.meas_cnt = cnt_q;
   assign bus.timeout  = to_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Self-checking bench: DDS-style ramps against a crossing-count reference model.
module tb_dds_freq_meter;
   import dds_meas_pkg::*;

   localparam int unsigned DAT_W  = 16;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned NCYC_W = 8;
   localparam int          BUDGET = 20000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dds_freq_meter_if #(.DAT_W(DAT_W), .CNT_W(CNT_W), .NCYC_W(NCYC_W)) bus ();

   dds_freq_meter #(.DAT_W(DAT_W), .CNT_W(CNT_W), .NCYC_W(NCYC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          tests_run = 0;
   int          fails = 0;
   logic        m_hyst = 1'b0;
   logic [23:0] phase = '0;
   logic [23:0] fw = 24'h010000;

   // kind 0: ramp, 1: constant mid-band, 2: ramp with noise kept inside the band
   function automatic logic [15:0] wave(input int kind, input logic [23:0] ph);
      logic [15:0] v;
      v = 16'(ph >> 9);
      if (kind == 1) begin
         v = 16'h3000;
      end else if (kind == 2 && v >= 16'h2800 && v <= 16'h3800) begin
         v = 16'(32'(v) + $urandom_range(0, 32'h0FFE) - 32'h07FF);
      end
      return v;
   endfunction

   task automatic drive_one(input bit vld, input int kind, output bit rise);
      logic [15:0] v;
      logic        nh;
      rise = 1'b0;
      bus.din_vld = vld;
      if (vld) begin
         v = wave(kind, phase);
         bus.din = v;
         phase = phase + fw;
         nh = m_hyst;
         if (v >= bus.thr_hi) nh = 1'b1;
         else if (v <= bus.thr_lo) nh = 1'b0;
         rise = !m_hyst && nh;
         m_hyst = nh;
      end
   endtask

   task automatic run_meas(input string name, input int ncyc, input int lim, input int kind,
                           input int div, input int restart_at, input int exp_const);
      int k, i, nr, r0, exp_cnt;
      bit pending, got, quiet, restarted, vld, rise, exp_to;
      k = (ncyc == 0) ? 1 : ncyc;
      i = 0; nr = 0; r0 = 0; exp_cnt = 0; exp_to = 1'b0;
      pending = 1'b0; got = 1'b0; quiet = 1'b1; restarted = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.ncyc = NCYC_W'(ncyc);
      bus.timeout_lim = CNT_W'(lim);
      bus.din_vld = 1'b0;
      for (int c = 0; c < BUDGET && !got; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.din_vld = 1'b0;
         if (pending) begin
            got = 1'b1;
            tests_run++;
            if (bus.meas_vld !== 1'b1) begin
               fails++; $display("FAIL %s meas_vld got %b expected 1", name, bus.meas_vld);
            end
            tests_run++;
            if (bus.meas_cnt !== CNT_W'(exp_cnt)) begin
               fails++; $display("FAIL %s meas_cnt got %0d expected %0d", name, bus.meas_cnt, exp_cnt);
            end
            tests_run++;
            if (bus.timeout !== exp_to) begin
               fails++; $display("FAIL %s timeout got %b expected %b", name, bus.timeout, exp_to);
            end
            tests_run++;
            if (bus.busy !== 1'b1) begin
               fails++; $display("FAIL %s busy_in_done got %b expected 1", name, bus.busy);
            end
            if (exp_const >= 0) begin
               tests_run++;
               if (bus.meas_cnt !== CNT_W'(exp_const)) begin
                  fails++; $display("FAIL %s meas_cnt_nominal got %0d expected %0d", name, bus.meas_cnt, exp_const);
               end
            end
         end else begin
            if (bus.meas_vld !== 1'b0 || bus.busy !== 1'b1) quiet = 1'b0;
            if (restart_at >= 0 && i == restart_at && !restarted) begin
               bus.start = 1'b1;
               bus.ncyc = NCYC_W'(1);
               restarted = 1'b1;
            end
            vld = (div == 0) ? ($urandom_range(0, 2) == 0) : ((c % div) == 0);
            drive_one(vld, kind, rise);
            if (vld) begin
               if (rise) begin
                  nr++;
                  if (nr == 1) r0 = i;
               end
               if (rise && nr == k + 1) begin
                  pending = 1'b1; exp_cnt = i - r0; exp_to = 1'b0;
               end else if (lim != 0 && i + 1 == lim) begin
                  pending = 1'b1; exp_cnt = 0; exp_to = 1'b1;
               end
               i++;
            end
         end
      end
      tests_run++;
      if (!quiet) begin
         fails++; $display("FAIL %s early meas_vld or busy drop got early expected none", name);
      end
      if (!got) begin
         tests_run++; fails++;
         $display("FAIL %s meas_vld got none expected pulse within %0d cycles", name, BUDGET);
         rst_n = 1'b0; m_hyst = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         @(negedge clk);
         tests_run++;
         if (bus.meas_vld !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL %s after_done vld/busy got %b/%b expected 0/0", name, bus.meas_vld, bus.busy);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b expected 0", bus.busy); end
      tests_run++;
      if (bus.meas_vld !== 1'b0) begin fails++; $display("FAIL reset meas_vld got %b expected 0", bus.meas_vld); end
      tests_run++;
      if (bus.meas_cnt !== '0) begin fails++; $display("FAIL reset meas_cnt got %0d expected 0", bus.meas_cnt); end
      tests_run++;
      if (bus.timeout !== 1'b0) begin fails++; $display("FAIL reset timeout got %b expected 0", bus.timeout); end
      rst_n = 1'b1;
   endtask

   task automatic test_ramp();
      phase = '0; fw = 24'h010000;
      bus.thr_hi = 16'h4000; bus.thr_lo = 16'h2000;
      run_meas("ramp_ncyc4", 4, 0, 0, 1, -1, 1024);
      run_meas("ramp_vld_div3", 4, 0, 0, 3, -1, 1024);
      run_meas("ramp_ncyc0", 0, 0, 0, 1, -1, 256);
   endtask

   task automatic test_timeout();
      run_meas("const_timeout", 4, 5000, 1, 1, -1, 0);
   endtask

   task automatic test_noise();
      fw = 24'h010000;
      run_meas("noisy_ncyc2", 2, 0, 2, 1, -1, 512);
   endtask

   task automatic test_reset_mid();
      bit r;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1; bus.ncyc = NCYC_W'(4); bus.timeout_lim = '0; bus.din_vld = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         drive_one(1'b1, 0, r);
      end
      @(negedge clk);
      bus.din_vld = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b expected 1", bus.busy); end
      rst_n = 1'b0; m_hyst = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tests_run++;
      if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_reset busy got %b expected 0", bus.busy); end
      tests_run++;
      if (bus.meas_cnt !== '0) begin fails++; $display("FAIL mid_reset meas_cnt got %0d expected 0", bus.meas_cnt); end
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (bus.meas_vld !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      tests_run++;
      if (seen) begin fails++; $display("FAIL mid_reset meas_vld got 1 expected 0"); end
      run_meas("restart_ignored", 4, 0, 0, 1, 300, 1024);
   endtask

   task automatic test_random();
      int lo, hi, ncyc, lim, kind, div;
      for (int n = 0; n < 8; n++) begin
         lo = int'($urandom_range(16'h0400, 16'h3000));
         hi = int'($urandom_range(lo + 16'h0800, 16'h7800));
         if ($urandom_range(0, 3) == 0) begin
            bus.thr_hi = 16'(lo); bus.thr_lo = 16'(hi);
         end else begin
            bus.thr_hi = 16'(hi); bus.thr_lo = 16'(lo);
         end
         fw   = 24'($urandom_range(24'h010000, 24'h040000));
         ncyc = int'($urandom_range(0, 4));
         lim  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 600)) : 0;
         kind = ($urandom_range(0, 1) == 0) ? 0 : 2;
         div  = int'($urandom_range(0, 3));
         run_meas($sformatf("random_%0d", n), ncyc, lim, kind, div, -1, -1);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.ncyc = '0; bus.thr_hi = 16'h4000; bus.thr_lo = 16'h2000;
      bus.timeout_lim = '0; bus.din_vld = 1'b0; bus.din = '0;
      test_reset();
      test_ramp();
      test_timeout();
      test_noise();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
